aq32_boot_mapper: RTL and testbench
===================================

# aq32_boot_mapper

Address-decode and handshake stage between the aq32 CPU bus and its two targets: the 512-byte registered boot ROM and main RAM. After reset the ROM is mapped over the low RAM window, and the block inserts the wait state the ROM's one-cycle registered read needs. A write to a control register unmaps the ROM. From then on every access goes to RAM.

## Interface
Parameters:
- ROM_BASE, 32'h0000_0000, byte base of the ROM window; must be 512-byte aligned.
- CTRL_ADDR, 32'hFFFF_FFF0, word address of the boot control register.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  32  byte address, stable while cpu_strobe high
- cpu_wrdata  in  32  write data
- cpu_bytesel  in  4  byte enables
- cpu_wren  in  1  1 = write, 0 = read
- cpu_strobe  in  1  request valid; held until accepted
- cpu_wait  out  1  1 = not complete this cycle
- cpu_rddata  out  32  read data, valid in the completing cycle
- rom_addr  out  9  ROM word address, {cpu_addr[8:2],2'b00}
- rom_rddata  in  32  ROM data, registered, one cycle after rom_addr
- ram_addr / ram_wrdata / ram_bytesel / ram_wren  out  32/32/4/1  passthrough of the cpu_* fields
- ram_strobe  out  1  RAM request
- ram_wait  in  1  RAM stall
- ram_rddata  in  32  RAM read data
- boot_mode  out  1  1 = ROM mapped

## Operation
- Handshake: a transfer completes in the cycle where cpu_strobe=1 and cpu_wait=0.
- Decode, evaluated combinationally each cycle:
  - sel_ctrl = cpu_addr[31:2]==CTRL_ADDR[31:2].
  - sel_rom = boot_mode and cpu_addr[31:9]==ROM_BASE[31:9] and not sel_ctrl.
  - sel_ram = otherwise.
- States: IDLE, ROM_RD.
  - IDLE, strobe, sel_rom, read: cpu_wait=1, next ROM_RD.
  - ROM_RD: cpu_wait=0, cpu_rddata=rom_rddata, next IDLE. The request completes here regardless of the strobe level.
  - IDLE, strobe, sel_rom, write: write discarded, cpu_wait=0, ROM contents unaffected.
  - IDLE, strobe, sel_ctrl:
    - cpu_wait=0.
    - Read returns {31'b0, boot_mode}.
    - Write with cpu_bytesel[0]=1 and cpu_wrdata[0]=1 clears boot_mode at the clock edge. The transfer completes in that same cycle.
  - IDLE, strobe, sel_ram:
    - ram_strobe=1, cpu_wait=ram_wait, cpu_rddata=ram_rddata.
    - In all other cycles ram_strobe=0.
- rddata mux: ROM data in ROM_RD, control value on sel_ctrl, RAM data otherwise.
- boot_mode changes only at a clock edge. A request in flight in ROM_RD always finishes from the ROM, even if boot_mode clears in the same cycle.
- After boot_mode=0, the ROM window addresses reach RAM unchanged, with no address translation.

## Timing
- ROM read latency: 2 cycles from strobe to completion, with exactly 1 wait cycle.
- Control register access and ROM writes: 0 wait cycles.
- RAM access: wait cycles equal to ram_wait, with a purely combinational path.
- Back-to-back ROM reads: the next request is accepted in the IDLE cycle after ROM_RD. Sustained throughput is 1 word per 2 cycles.
- While reset=1:
  - cpu_wait=1, ram_strobe=0, cpu_rddata=0.
  - State forced to IDLE, boot_mode loaded to 1.
  - Requests are ignored.
- Reset asserted while in ROM_RD: the request is abandoned and is not completed.

## Configuration
- BOOTMAP_REARM_EN defined: a control write with bytesel[0]=1 and wrdata[1]=1 sets boot_mode=1. When wrdata[0] and wrdata[1] are both 1, clear wins.
- BOOTMAP_REARM_EN not defined: wrdata[1] is ignored. Only reset sets boot_mode, so the ROM stays unmapped once cleared.

## Test plan
- Reset, then read 0x000 → cpu_wait=1 for 1 cycle, then cpu_rddata=32'h00001197. rom_addr=0 and ram_strobe stays 0.
- Back-to-back reads of 0x05C and 0x060 → 32'h0000006F then 32'h00000000, each 2 cycles.
- Write 1 to CTRL_ADDR, then read 0x000 with ram_wait high for 3 cycles → ram_strobe=1, 3 wait cycles, cpu_rddata=ram_rddata. A CTRL read returns 0.
- Write 0xFFFFFFFF to 0x010 while boot_mode=1 → completes with 0 waits and ram_strobe=0. A following read of 0x010 returns 32'h00000293.
- Write 2 to CTRL_ADDR after clearing boot_mode → boot_mode=1 with BOOTMAP_REARM_EN defined and stays 0 without it. Write 3 → boot_mode=0 in both builds.
- Assert reset in the ROM_RD cycle → no completion, boot_mode=1, cpu_wait=1 during reset. The first post-reset read of 0x004 returns 32'h00018193.

Source files
------------

// File: rtl/aq32_boot_mapper_if.sv
// aq32_boot_mapper_if: CPU-side bus of the boot mapper.
// The CPU drives the request fields and the strobe. The mapper returns
// the wait flag and the read data. A transfer completes in the cycle
// where cpu_strobe=1 and cpu_wait=0.
interface aq32_boot_mapper_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wrdata;
  logic [3:0]  cpu_bytesel;
  logic        cpu_wren;
  logic        cpu_strobe;
  logic        cpu_wait;
  logic [31:0] cpu_rddata;

  modport master (
    output cpu_addr,
    output cpu_wrdata,
    output cpu_bytesel,
    output cpu_wren,
    output cpu_strobe,
    input  cpu_wait,
    input  cpu_rddata
  );

  modport slave (
    input  cpu_addr,
    input  cpu_wrdata,
    input  cpu_bytesel,
    input  cpu_wren,
    input  cpu_strobe,
    output cpu_wait,
    output cpu_rddata
  );
endinterface

// File: rtl/aq32_boot_mapper.sv
// aq32_boot_mapper: address decode and handshake between the aq32 CPU bus,
// the 512-byte registered boot ROM and main RAM.
// After reset the ROM overlays the low RAM window, and ROM reads take one
// wait state. Writing bit 0 of the control register unmaps the ROM.
// Optional feature macro: BOOTMAP_REARM_EN. When it is defined, writing
// bit 1 of the control register maps the ROM again. If bits 0 and 1 are
// both written as 1, the clear takes priority.
module aq32_boot_mapper #(
  parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
  parameter logic [31:0] CTRL_ADDR = 32'hFFFF_FFF0
) (
  input  logic                      clk,
  input  logic                      reset,
  aq32_boot_mapper_if.slave         cpu,
  output logic [8:0]                rom_addr,
  input  logic [31:0]               rom_rddata,
  output logic [31:0]               ram_addr,
  output logic [31:0]               ram_wrdata,
  output logic [3:0]                ram_bytesel,
  output logic                      ram_wren,
  output logic                      ram_strobe,
  input  logic                      ram_wait,
  input  logic [31:0]               ram_rddata,
  output logic                      boot_mode
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ROM_RD = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_boot_mode;

  logic        w_sel_ctrl;
  logic        w_sel_rom;
  logic        w_ctrl_wr;
  logic        w_boot_clr;
`ifdef BOOTMAP_REARM_EN
  logic        w_boot_set;
`endif
  logic        w_cpu_wait;
  logic [31:0] w_cpu_rddata;
  logic        w_ram_strobe;

  // Address decode. The control register takes priority over the ROM window.
  always_comb begin
    w_sel_ctrl = (cpu.cpu_addr[31:2] == CTRL_ADDR[31:2]);
    w_sel_rom  = r_boot_mode
                 && (cpu.cpu_addr[31:9] == ROM_BASE[31:9])
                 && !w_sel_ctrl;
  end

  // Control register write qualifiers. Only an accepted IDLE-cycle access counts.
  always_comb begin
    w_ctrl_wr  = !reset && (r_state == S_IDLE) && cpu.cpu_strobe
                 && w_sel_ctrl && cpu.cpu_wren && cpu.cpu_bytesel[0];
    w_boot_clr = w_ctrl_wr && cpu.cpu_wrdata[0];
`ifdef BOOTMAP_REARM_EN
    w_boot_set = w_ctrl_wr && cpu.cpu_wrdata[1] && !cpu.cpu_wrdata[0];
`endif
  end

  // State register. Reset abandons any ROM read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Boot mode flag. It changes only at a clock edge, so a ROM_RD cycle
  // always completes from the ROM even if the flag clears in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_boot_mode <= 1'b1;
    end else if (w_boot_clr) begin
      r_boot_mode <= 1'b0;
`ifdef BOOTMAP_REARM_EN
    end else if (w_boot_set) begin
      r_boot_mode <= 1'b1;
`endif
    end
  end

  // Next state, handshake, and read-data mux.
  always_comb begin
    w_next_state = r_state;
    w_cpu_wait   = 1'b0;
    w_cpu_rddata = '0;
    w_ram_strobe = 1'b0;

    if (reset) begin
      w_next_state = S_IDLE;
      w_cpu_wait   = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_sel_ctrl) begin
            w_cpu_rddata = {31'b0, r_boot_mode};
          end else begin
            w_cpu_rddata = ram_rddata;
          end

          if (cpu.cpu_strobe) begin
            if (w_sel_ctrl) begin
              w_cpu_wait = 1'b0;
            end else if (w_sel_rom) begin
              if (cpu.cpu_wren) begin
                // A ROM write completes immediately and is dropped.
                w_cpu_wait = 1'b0;
              end else begin
                // The registered ROM needs one cycle before its data is valid.
                w_cpu_wait   = 1'b1;
                w_next_state = S_ROM_RD;
              end
            end else begin
              w_ram_strobe = 1'b1;
              w_cpu_wait   = ram_wait;
            end
          end
        end

        S_ROM_RD: begin
          // Completes whatever the strobe level is.
          w_cpu_wait   = 1'b0;
          w_cpu_rddata = rom_rddata;
          w_next_state = S_IDLE;
        end

        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  // Output wiring. RAM fields pass through unchanged; the ROM address is word-aligned.
  always_comb begin
    cpu.cpu_wait   = w_cpu_wait;
    cpu.cpu_rddata = w_cpu_rddata;
    rom_addr       = {cpu.cpu_addr[8:2], 2'b00};
    ram_addr       = cpu.cpu_addr;
    ram_wrdata     = cpu.cpu_wrdata;
    ram_bytesel    = cpu.cpu_bytesel;
    ram_wren       = cpu.cpu_wren;
    ram_strobe     = w_ram_strobe;
    boot_mode      = r_boot_mode;
  end

endmodule

// File: tb/tb_aq32_boot_mapper.sv
// tb_aq32_boot_mapper: directed testbench for aq32_boot_mapper.
// It models a registered boot ROM and a RAM whose wait count can be programmed.
module tb_aq32_boot_mapper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [8:0]  rom_addr;
  logic [31:0] rom_rddata;
  logic [31:0] ram_addr;
  logic [31:0] ram_wrdata;
  logic [3:0]  ram_bytesel;
  logic        ram_wren;
  logic        ram_strobe;
  logic        ram_wait;
  logic [31:0] ram_rddata;
  logic        boot_mode;

  aq32_boot_mapper_if bus();

  aq32_boot_mapper #(
    .ROM_BASE  (32'h0000_0000),
    .CTRL_ADDR (32'hFFFF_FFF0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu         (bus),
    .rom_addr    (rom_addr),
    .rom_rddata  (rom_rddata),
    .ram_addr    (ram_addr),
    .ram_wrdata  (ram_wrdata),
    .ram_bytesel (ram_bytesel),
    .ram_wren    (ram_wren),
    .ram_strobe  (ram_strobe),
    .ram_wait    (ram_wait),
    .ram_rddata  (ram_rddata),
    .boot_mode   (boot_mode)
  );

  // Registered ROM: data appears one cycle after the address.
  logic [31:0] rom_mem [0:127];
  always @(posedge clk) rom_rddata <= rom_mem[rom_addr[8:2]];

  // RAM: waits for ram_wait_cnt strobed cycles. Read data is derived from the address.
  int unsigned ram_wait_cnt;
  assign ram_wait   = (ram_wait_cnt != 0);
  assign ram_rddata = ram_addr ^ 32'hA5A5_0000;
  always @(posedge clk) if (ram_strobe && ram_wait_cnt != 0) ram_wait_cnt <= ram_wait_cnt - 1;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] CTRL = 32'hFFFF_FFF0;
`ifdef BOOTMAP_REARM_EN
  localparam logic [31:0] REARM_EXP = 32'd1;
`else
  localparam logic [31:0] REARM_EXP = 32'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus transfer. It starts #1 after a posedge and ends #1 after the completing posedge.
  task automatic access(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output int waits,
                        output logic saw_ram, output logic [8:0] saw_rom_addr);
    logic done;
    bus.cpu_addr    = addr;
    bus.cpu_wren    = wr;
    bus.cpu_wrdata  = wd;
    bus.cpu_bytesel = be;
    bus.cpu_strobe  = 1'b1;
    waits = 0; saw_ram = 1'b0; rd = '0; done = 1'b0; saw_rom_addr = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      saw_ram      = saw_ram | ram_strobe;
      saw_rom_addr = rom_addr;
      if (!bus.cpu_wait) begin
        rd   = bus.cpu_rddata;
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    bus.cpu_strobe = 1'b0;
    if (!done) chk("timeout", {31'b0, done}, 32'd1);
  endtask

  logic [31:0] rd;
  int          w;
  logic        sr;
  logic [8:0]  ra;

  initial begin
    for (int i = 0; i < 128; i++) rom_mem[i] = 32'h0BAD_0000 | i;
    rom_mem[0]  = 32'h0000_1197;
    rom_mem[1]  = 32'h0001_8193;
    rom_mem[4]  = 32'h0000_0293;
    rom_mem[23] = 32'h0000_006F;
    rom_mem[24] = 32'h0000_0000;
    ram_wait_cnt    = 0;
    reset           = 1'b1;
    bus.cpu_addr    = '0;
    bus.cpu_wrdata  = '0;
    bus.cpu_bytesel = '0;
    bus.cpu_wren    = 1'b0;
    bus.cpu_strobe  = 1'b0;

    // Reset: a request is presented and ignored.
    repeat (2) @(posedge clk);
    #1 bus.cpu_strobe = 1'b1;
    @(negedge clk);
    chk("rst_wait",   {31'b0, bus.cpu_wait}, 32'd1);
    chk("rst_ramstb", {31'b0, ram_strobe},   32'd0);
    chk("rst_rddata", bus.cpu_rddata,        32'd0);
    chk("rst_boot",   {31'b0, boot_mode},    32'd1);
    @(posedge clk); #1;
    bus.cpu_strobe = 1'b0;
    reset = 1'b0;

    // ROM read of 0x000.
    access(32'h000, 1'b0, '0, 4'hF, rd, w, sr, ra);
    chk("rom0_data",  rd, 32'h0000_1197);
    chk("rom0_waits", w, 32'd1);
    chk("rom0_ram",   {31'b0, sr}, 32'd0);
    chk("rom0_addr",  {23'b0, ra}, 32'd0);

    // Back-to-back ROM reads.
    access(32'h05C, 1'b0, '0, 4'hF, rd, w, sr, ra);
    chk("rom5c_data",  rd, 32'h0000_006F);
    chk("rom5c_waits", w, 32'd1);
    access(32'h060, 1'b0, '0, 4'hF, rd, w, sr, ra);
    chk("rom60_data",  rd, 32'h0000_0000);
    chk("rom60_waits", w, 32'd1);
    chk("rom60_addr",  {23'b0, ra}, 32'h060);

    // Control read while mapped.
    access(CTRL, 1'b0, '0, 4'hF, rd, w, sr, ra);
    chk("ctrl_rd1",   rd, 32'd1);
    chk("ctrl_rd1_w", w, 32'd0);

    // A ROM write is discarded with no wait and no RAM strobe.
    access(32'h010, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, w, sr, ra);
    chk("romwr_waits", w, 32'd0);
    chk("romwr_ram",   {31'b0, sr}, 32'd0);
    access(32'h010, 1'b0, '0, 4'hF, rd, w, sr, ra);
    chk("rom10_data",  rd, 32'h0000_0293);

    // A RAM write outside the ROM window passes its fields through.
    access(32'h400, 1'b1, 32'h1234_5678, 4'b0110, rd, w, sr, ra);
    chk("ramwr_waits", w, 32'd0);
    chk("ramwr_stb",   {31'b0, sr}, 32'd1);
    chk("ramwr_addr",  ram_addr, 32'h400);
    chk("ramwr_data",  ram_wrdata, 32'h1234_5678);
    chk("ramwr_be",    {28'b0, ram_bytesel}, 32'h6);
    chk("ramwr_wren",  {31'b0, ram_wren}, 32'd1);
    chk("boot_still",  {31'b0, boot_mode}, 32'd1);

    // Unmap the ROM.
    access(CTRL, 1'b1, 32'd1, 4'h1, rd, w, sr, ra);
    chk("ctrl_wr_w",  w, 32'd0);
    chk("boot_clr",   {31'b0, boot_mode}, 32'd0);
    access(CTRL, 1'b0, '0, 4'hF, rd, w, sr, ra);
    chk("ctrl_rd0",   rd, 32'd0);

    // The ROM window now reaches RAM, which stretches the access by 3 waits.
    ram_wait_cnt = 3;
    access(32'h000, 1'b0, '0, 4'hF, rd, w, sr, ra);
    chk("ram0_waits", w, 32'd3);
    chk("ram0_stb",   {31'b0, sr}, 32'd1);
    chk("ram0_data",  rd, 32'hA5A5_0000);
    chk("ram0_addr",  ram_addr, 32'h000);

    // Rearm attempt, then a write of 3 (clear wins).
    access(CTRL, 1'b1, 32'd2, 4'h1, rd, w, sr, ra);
    chk("rearm",      {31'b0, boot_mode}, REARM_EXP);
    access(CTRL, 1'b1, 32'd3, 4'h1, rd, w, sr, ra);
    chk("wr3_clear",  {31'b0, boot_mode}, 32'd0);

    // Reset pulse remaps the ROM.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst2_boot",  {31'b0, boot_mode}, 32'd1);

    // Reset arriving in the ROM_RD cycle abandons the read.
    bus.cpu_addr   = 32'h004;
    bus.cpu_wren   = 1'b0;
    bus.cpu_strobe = 1'b1;
    @(negedge clk);
    chk("abort_idle_w", {31'b0, bus.cpu_wait}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_wait",   {31'b0, bus.cpu_wait}, 32'd1);
    chk("abort_rddata", bus.cpu_rddata, 32'd0);
    @(posedge clk); #1;
    bus.cpu_strobe = 1'b0;
    @(negedge clk);
    chk("abort_wait2",  {31'b0, bus.cpu_wait}, 32'd1);
    chk("abort_boot",   {31'b0, boot_mode}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    access(32'h004, 1'b0, '0, 4'hF, rd, w, sr, ra);
    chk("rom4_data",  rd, 32'h0001_8193);
    chk("rom4_waits", w, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
